// File: rtl/divide_by_ten.sv
// divide_by_ten: sequential 13-bit unsigned divide-by-ten.
// One restoring-division step per clock; 13 steps per operation, data-independent.
// Quotient/Remainder are registered and only change on completion.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous, active-high reset
//   Start      request; accepted only while Busy=0
//   X          13-bit unsigned dividend, sampled on the accepting edge
//   Busy       high while a division is in progress
//   Done       one-cycle pulse when Quotient/Remainder are updated
//   Quotient   floor(X/10), 0..819
//   Remainder  X mod 10, 0..9
module divide_by_ten (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [12:0] X,
    output logic        Busy,
    output logic        Done,
    output logic [12:0] Quotient,
    output logic [3:0]  Remainder
);

    typedef enum logic {
        StIdle,
        StRun
    } state_e;

    state_e      state_q, state_d;
    logic [12:0] d_q, d_d;      // dividend shifts out the top, quotient bits shift in
    logic [4:0]  r_q, r_d;      // partial remainder, always < 10 between steps
    logic [3:0]  c_q, c_d;      // steps remaining minus one
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [12:0] quo_q, quo_d;
    logic [3:0]  rem_q, rem_d;

    // Single restoring step. Since R < 10, T = 2R + bit <= 19 fits in 5 bits.
    logic [4:0]  t;
    logic        step_ge;
    logic [4:0]  r_step;
    logic [12:0] d_step;

    always_comb begin
        t       = {r_q[3:0], d_q[12]};
        step_ge = (t >= 5'd10);
        r_step  = step_ge ? (t - 5'd10) : t;
        d_step  = {d_q[11:0], step_ge};
    end

    always_comb begin
        state_d = state_q;
        d_d     = d_q;
        r_d     = r_q;
        c_d     = c_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        quo_d   = quo_q;
        rem_d   = rem_q;

        unique case (state_q)
            StIdle: begin
                if (Start) begin
                    d_d     = X;
                    r_d     = 5'd0;
                    c_d     = 4'd12;
                    busy_d  = 1'b1;
                    state_d = StRun;
                end
            end
            StRun: begin
                d_d = d_step;
                r_d = r_step;
                if (c_q == 4'd0) begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    quo_d   = d_step;
                    rem_d   = r_step[3:0];
                end else begin
                    c_d = c_q - 4'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            d_q     <= '0;
            r_q     <= '0;
            c_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            d_q     <= d_d;
            r_q     <= r_d;
            c_q     <= c_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
        end
    end

    assign Busy      = busy_q;
    assign Done      = done_q;
    assign Quotient  = quo_q;
    assign Remainder = rem_q;

endmodule
